if_prefetch_stage: RTL

//  Instruction-fetch stage with a parametrised prefetch queue. It decouples fetch from decode.
//  It issues sequential fetch requests to a variable-latency, in-order instruction memory and buffers the returned words.
//  It delivers {PC, NPC, IR} to decode through a valid/ready handshake.
//  A taken branch from EX redirects the stage: the queue is flushed and stale in-flight responses are discarded.

---
 rtl/if_pkg.sv | 18 +
 rtl/if_fetch_fifo.sv | 78 +++++++
 rtl/if_prefetch_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared types and constants for the instruction-fetch stage.
//   XLEN          : width of PCs and instruction words held in the queue
//   INST_BYTES    : byte distance between consecutive instructions
//   fetch_entry_t : one prefetch-queue entry, {pc, ir}
// ----------------------------------------------------------------------------
package if_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// ----------------------------------------------------------------------------
// if_fetch_fifo
// Synchronous circular FIFO of DEPTH entries of type T (DEPTH a power of 2).
// Used both as the prefetch queue and as the tracker of in-flight fetch PCs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : empties the FIFO (wins over push/pop)
//   push_i     : write data_i at the tail (accepted when not full, or full
//                with a simultaneous pop)
//   pop_i      : drop the head (ignored when empty)
//   data_o     : current head entry, straight from the storage registers
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   count_o    : number of entries held
// ----------------------------------------------------------------------------
module if_fetch_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal together with a pop of the head.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is reset as well so the head output is never X, even before the
  // first write. Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// ----------------------------------------------------------------------------
// if_prefetch_stage
// Instruction-fetch stage with a prefetch queue between an in-order,
// variable-latency instruction memory and decode.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ex_take_branch_out  : taken-branch redirect from EX (single cycle)
//   ex_target_PC_out    : redirect target (low two bits ignored)
//   proc2Imem_req/_addr : fetch request and word-aligned fetch address
//   Imem2proc_gnt       : memory accepts the request this cycle
//   Imem2proc_rvalid    : in-order response valid
//   Imem2proc_data      : response instruction word
//   if_valid_inst_out   : queue head valid to decode
//   id_ready_in         : decode accepts the head this cycle
//   if_PC_out/_NPC_out  : head PC and PC+4
//   if_IR_out           : head instruction word
// XLEN must match if_pkg::XLEN because the queue entry type comes from there.
// ----------------------------------------------------------------------------
module if_prefetch_stage #(
  parameter int              XLEN     = 32,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_take_branch_out,
  input  logic [XLEN-1:0] ex_target_PC_out,
  output logic            proc2Imem_req,
  output logic [XLEN-1:0] proc2Imem_addr,
  input  logic            Imem2proc_gnt,
  input  logic            Imem2proc_rvalid,
  input  logic [XLEN-1:0] Imem2proc_data,
  output logic            if_valid_inst_out,
  input  logic            id_ready_in,
  output logic [XLEN-1:0] if_PC_out,
  output logic [XLEN-1:0] if_NPC_out,
  output logic [XLEN-1:0] if_IR_out
);

  import if_pkg::*;

  localparam int            CW      = $clog2(FQ_DEPTH+1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FQ_DEPTH);

  typedef logic [XLEN-1:0] word_t;

  word_t         fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q,  discard_d;

  logic          fq_push, fq_pop, fq_clear;
  logic          fq_full, fq_empty;
  logic [CW-1:0] fq_count;
  fetch_entry_t  fq_wdata, fq_head;

  word_t         pc_head;
  logic          pc_full, pc_empty;
  logic [CW-1:0] pc_count;

  logic [CW:0]   credit_used;
  logic          grant;

  // Credits are computed from registered occupancy only: every granted
  // request already owns a queue slot, so a response can always be pushed.
  // The request is held low while in reset so the memory never sees a
  // request before the stage is out of reset.
  assign credit_used    = {1'b0, fq_count} + {1'b0, inflight_q};
  assign proc2Imem_req  = rst_n && !ex_take_branch_out && (credit_used < DEPTH_C);
  assign proc2Imem_addr = {fetch_pc_q[XLEN-1:2], 2'b00};
  assign grant          = proc2Imem_req && Imem2proc_gnt;

  assign fq_wdata = '{pc: pc_head, ir: Imem2proc_data};

  // Next-state logic. A redirect overrides queue traffic and turns every
  // word still in flight into a stale one. Words already marked for discard
  // are a subset of those in flight, so the new discard count is simply what
  // remains in flight after this cycle's response.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CW'(grant) - CW'(Imem2proc_rvalid);
    discard_d  = discard_q;
    fq_push    = 1'b0;
    fq_pop     = 1'b0;
    fq_clear   = 1'b0;

    if (grant) begin
      fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
    end

    if (ex_take_branch_out) begin
      fetch_pc_d = {ex_target_PC_out[XLEN-1:2], 2'b00};
      fq_clear   = 1'b1;
      discard_d  = inflight_q - CW'(Imem2proc_rvalid);
    end else begin
      if (Imem2proc_rvalid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          fq_push = 1'b1;
        end
      end
      fq_pop = !fq_empty && id_ready_in;
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // Prefetch queue: decode sees its head directly from registers.
  if_fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (fq_clear),
    .push_i  (fq_push),
    .data_i  (fq_wdata),
    .pop_i   (fq_pop),
    .data_o  (fq_head),
    .full_o  (fq_full),
    .empty_o (fq_empty),
    .count_o (fq_count)
  );

  // PCs of granted requests, in order. Popped on every response, stale or
  // not, so it never needs clearing on a redirect.
  if_fetch_fifo #(
    .T     (word_t),
    .DEPTH (FQ_DEPTH)
  ) u_pc_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (1'b0),
    .push_i  (grant),
    .data_i  (proc2Imem_addr),
    .pop_i   (Imem2proc_rvalid),
    .data_o  (pc_head),
    .full_o  (pc_full),
    .empty_o (pc_empty),
    .count_o (pc_count)
  );

  assign if_valid_inst_out = !fq_empty;
  assign if_PC_out         = fq_head.pc;
  assign if_NPC_out        = fq_head.pc + XLEN'(INST_BYTES);
  assign if_IR_out         = fq_head.ir;

  // Protocol and occupancy invariants.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(Imem2proc_rvalid && (inflight_q == '0)));
      assert (credit_used <= DEPTH_C);
      assert (pc_count == inflight_q);
      assert (!(Imem2proc_rvalid && pc_empty));
      assert (!(grant && pc_full && !Imem2proc_rvalid));
      assert (!(fq_push && fq_full && !fq_pop));
    end
  end

endmodule
